// File: rtl/mby_txc_pkg.sv
// Shared types and constants for the TXC segment receive path from EPB.
package mby_txc_pkg;

  localparam int TXC_SEG_W    = 256;
  localparam int TXC_RX_DEPTH = 8;
  localparam int TXC_EB_W     = $clog2(TXC_SEG_W / 8);

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } txc_rx_state_e;

  typedef struct packed {
    logic                 sop;
    logic                 eop;
    logic [TXC_EB_W-1:0]  ebytes;
    logic [TXC_SEG_W-1:0] data;
  } txc_seg_t;

endpackage

// File: rtl/txc_epb_rx_fifo.sv
// Single-clock FIFO; read data is the head entry, valid whenever empty is low.
module txc_epb_rx_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/txc_epb_rx.sv
// EPB-to-MAC segment receiver: buffers segments, returns credits, tracks framing.
module txc_epb_rx
  import mby_txc_pkg::*;
#(
  parameter  int DATA_W = TXC_SEG_W,
  parameter  int DEPTH  = TXC_RX_DEPTH,
  localparam int EB_W   = $clog2(DATA_W / 8),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              cclk,
  input  logic              rst_n,
  input  logic              epb_txc_vld,
  input  logic              epb_txc_sop,
  input  logic              epb_txc_eop,
  input  logic [DATA_W-1:0] epb_txc_data,
  input  logic [EB_W-1:0]   epb_txc_ebytes,
  output logic              txc_epb_crd,
  output logic              tx_vld,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic [DATA_W-1:0] tx_data,
  output logic [EB_W-1:0]   tx_ebytes,
  input  logic              tx_rdy,
  output logic              err_ovf,
  output logic              err_sop,
  output logic              err_nosop,
  output logic [31:0]       pkt_cnt,
  output txc_rx_state_e     dbg_state,
  output logic [CNT_W-1:0]  dbg_occ
);

  localparam int SEG_W = DATA_W + EB_W + 2;

  // Handshake: EPB has no ready; it may only send while it holds a credit, and a
  // segment arriving on a full FIFO is dropped. Toward the MAC, a segment moves
  // when tx_vld && tx_rdy; tx_* stay stable while tx_vld is high and tx_rdy low.
  logic             fifo_full, fifo_empty;
  logic [SEG_W-1:0] fifo_rdata;
  logic             push, pop;

  txc_rx_state_e state_q, state_d;
  logic          crd_q, crd_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_sop_q, err_sop_d;
  logic          err_nosop_q, err_nosop_d;
  logic [31:0]   pkt_cnt_q, pkt_cnt_d;

  assign push = epb_txc_vld && !fifo_full;
  assign pop  = tx_vld && tx_rdy;

  txc_epb_rx_fifo #(
    .W     (SEG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (cclk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({epb_txc_sop, epb_txc_eop, epb_txc_ebytes, epb_txc_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (dbg_occ)
  );

  assign tx_vld = !fifo_empty;
  assign {tx_sop, tx_eop, tx_ebytes, tx_data} = fifo_rdata;

  always_comb begin
    state_d     = state_q;
    crd_d       = pop;
    err_ovf_d   = err_ovf_q;
    err_sop_d   = err_sop_q;
    err_nosop_d = err_nosop_q;
    pkt_cnt_d   = pkt_cnt_q + 32'(pop && tx_eop);
    if (epb_txc_vld && fifo_full) err_ovf_d = 1'b1;
    // Framing errors are flagged but the segment is kept and framing resyncs on it.
    if (push) begin
      if (state_q == IN_PKT && epb_txc_sop)  err_sop_d   = 1'b1;
      if (state_q == IDLE   && !epb_txc_sop) err_nosop_d = 1'b1;
      state_d = epb_txc_eop ? IDLE : IN_PKT;
    end
  end

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      crd_q       <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_sop_q   <= 1'b0;
      err_nosop_q <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      crd_q       <= crd_d;
      err_ovf_q   <= err_ovf_d;
      err_sop_q   <= err_sop_d;
      err_nosop_q <= err_nosop_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign txc_epb_crd = crd_q;
  assign err_ovf     = err_ovf_q;
  assign err_sop     = err_sop_q;
  assign err_nosop   = err_nosop_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_txc_epb_rx.sv
// Scoreboard bench for txc_epb_rx: queue-based reference model checked every cycle.
module tb_txc_epb_rx;
  import mby_txc_pkg::*;

  localparam int DATA_W = 256;
  localparam int DEPTH  = 8;
  localparam int EB_W   = $clog2(DATA_W / 8);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int SEG_W  = DATA_W + EB_W + 2;

  // clock / reset
  logic cclk = 1'b0;
  logic rst_n;
  always #5 cclk = ~cclk;

  logic              epb_txc_vld, epb_txc_sop, epb_txc_eop;
  logic [DATA_W-1:0] epb_txc_data;
  logic [EB_W-1:0]   epb_txc_ebytes;
  logic              txc_epb_crd, tx_vld, tx_sop, tx_eop, tx_rdy;
  logic [DATA_W-1:0] tx_data;
  logic [EB_W-1:0]   tx_ebytes;
  logic              err_ovf, err_sop, err_nosop;
  logic [31:0]       pkt_cnt;
  txc_rx_state_e     dbg_state;
  logic [CNT_W-1:0]  dbg_occ;

  txc_epb_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .cclk           (cclk),
    .rst_n          (rst_n),
    .epb_txc_vld    (epb_txc_vld),
    .epb_txc_sop    (epb_txc_sop),
    .epb_txc_eop    (epb_txc_eop),
    .epb_txc_data   (epb_txc_data),
    .epb_txc_ebytes (epb_txc_ebytes),
    .txc_epb_crd    (txc_epb_crd),
    .tx_vld         (tx_vld),
    .tx_sop         (tx_sop),
    .tx_eop         (tx_eop),
    .tx_data        (tx_data),
    .tx_ebytes      (tx_ebytes),
    .tx_rdy         (tx_rdy),
    .err_ovf        (err_ovf),
    .err_sop        (err_sop),
    .err_nosop      (err_nosop),
    .pkt_cnt        (pkt_cnt),
    .dbg_state      (dbg_state),
    .dbg_occ        (dbg_occ)
  );

  // scoreboard state
  logic [SEG_W-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_pass   = 0;
  bit               in_pkt, m_ovf, m_sop, m_nosop, m_crd;
  logic [31:0]      m_cnt;
  logic [SEG_W-1:0] head;
  bit               m_pop, m_acc;

  task automatic check(input string name, input logic [SEG_W-1:0] act,
                       input logic [SEG_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    in_pkt  = 1'b0;
    m_ovf   = 1'b0;
    m_sop   = 1'b0;
    m_nosop = 1'b0;
    m_crd   = 1'b0;
    m_cnt   = '0;
  endtask

  // monitor: compare this cycle's outputs, then advance the model across the next edge
  always @(negedge cclk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      check("tx_vld", SEG_W'(tx_vld), SEG_W'(exp_q.size() != 0));
      if (tx_vld && exp_q.size() != 0)
        check("tx_seg", {tx_sop, tx_eop, tx_ebytes, tx_data}, exp_q[0]);
      check("crd", SEG_W'(txc_epb_crd), SEG_W'(m_crd));
      check("errs", SEG_W'({err_ovf, err_sop, err_nosop}), SEG_W'({m_ovf, m_sop, m_nosop}));
      check("pkt_cnt", SEG_W'(pkt_cnt), SEG_W'(m_cnt));
      check("state", SEG_W'(dbg_state == IN_PKT), SEG_W'(in_pkt));
      check("occ", SEG_W'(dbg_occ), SEG_W'(exp_q.size()));
      m_pop = (exp_q.size() != 0) && tx_rdy;
      m_acc = epb_txc_vld && (exp_q.size() < DEPTH);
      m_crd = m_pop;
      if (epb_txc_vld && !m_acc) m_ovf = 1'b1;
      if (m_acc) begin
        if (in_pkt && epb_txc_sop)   m_sop   = 1'b1;
        if (!in_pkt && !epb_txc_sop) m_nosop = 1'b1;
        in_pkt = !epb_txc_eop;
      end
      if (m_pop) begin
        head = exp_q.pop_front();
        if (head[SEG_W-2]) m_cnt = m_cnt + 32'd1;
      end
      if (m_acc) exp_q.push_back({epb_txc_sop, epb_txc_eop, epb_txc_ebytes, epb_txc_data});
    end
  end

  // driver tasks
  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic drive(input bit vld, input bit s, input bit e,
                       input logic [EB_W-1:0] eb, input bit rdy);
    @(posedge cclk); #1;
    epb_txc_vld    = vld;
    epb_txc_sop    = s;
    epb_txc_eop    = e;
    epb_txc_ebytes = eb;
    epb_txc_data   = rand_data();
    tx_rdy         = rdy;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, rdy);
  endtask

  task automatic do_reset();
    @(posedge cclk); #1;
    rst_n = 1'b0;
    epb_txc_vld = 1'b0;
    repeat (2) @(posedge cclk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    epb_txc_vld = 1'b0; epb_txc_sop = 1'b0; epb_txc_eop = 1'b0;
    epb_txc_data = '0; epb_txc_ebytes = '0; tx_rdy = 1'b0;
    repeat (3) @(posedge cclk);
    #1;
    check("rst_tx_vld", SEG_W'(tx_vld), '0);
    check("rst_crd", SEG_W'(txc_epb_crd), '0);
    check("rst_errs", SEG_W'({err_ovf, err_sop, err_nosop}), '0);
    check("rst_pkt_cnt", SEG_W'(pkt_cnt), '0);
    rst_n = 1'b1;

    // single-segment packet with ebytes=5
    drive(1'b1, 1'b1, 1'b1, 5'd5, 1'b1);
    idle(4, 1'b1);
    check("single_pkt_cnt", SEG_W'(pkt_cnt), SEG_W'(32'd1));

    // backpressure fill: 8 accepted, 9th dropped, then drain
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, 1'b1, EB_W'($urandom_range(0, 31)), 1'b0);
    idle(12, 1'b1);
    check("fill_ovf", SEG_W'(err_ovf), SEG_W'(1'b1));
    check("fill_pkt_cnt", SEG_W'(pkt_cnt), SEG_W'(32'd9));

    // streaming at occupancy 7
    do_reset();
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 1'b1, EB_W'($urandom_range(0, 31)), 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b1, EB_W'($urandom_range(0, 31)), 1'b1);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    #1 check("stream_occ", SEG_W'(dbg_occ), SEG_W'(7));
    check("stream_errs", SEG_W'({err_ovf, err_sop, err_nosop}), '0);
    idle(10, 1'b1);

    // framing: sop, sop (no eop), eop
    do_reset();
    drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 5'd3, 1'b1);
    idle(4, 1'b1);
    check("frame_sop", SEG_W'({err_sop, err_nosop}), SEG_W'(2'b10));
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 5'd1, 1'b1);
    idle(4, 1'b1);
    check("frame_nosop", SEG_W'({err_sop, err_nosop}), SEG_W'(2'b01));

    // reset mid-packet with 3 segments buffered
    do_reset();
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    #1 check("mid_state", SEG_W'(dbg_state == IN_PKT), SEG_W'(1'b1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", SEG_W'(tx_vld), '0);
    check("mid_rst_crd", SEG_W'(txc_epb_crd), '0);
    check("mid_rst_state", SEG_W'(dbg_state == IN_PKT), '0);
    check("mid_rst_cnt", SEG_W'(pkt_cnt), '0);
    repeat (2) @(posedge cclk);
    #1 rst_n = 1'b1;
    tx_rdy = 1'b1;
    idle(6, 1'b1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            EB_W'($urandom_range(0, 31)), $urandom_range(0, 9) < 7);
    idle(12, 1'b1);

    // counter wrap
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #2 release dut.pkt_cnt_q;
    drive(1'b1, 1'b1, 1'b1, 5'd7, 1'b1);
    idle(4, 1'b1);
    check("wrap_cnt", SEG_W'(pkt_cnt), '0);

    idle(3, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
